weight_pattern_gen: RTL and testbench
=====================================

Name: weight_pattern_gen

Overview:
Sequential generator that builds a 32-bit word containing exactly WEIGHT ones. It is the inverse of the popcount path: calc_hamming counts the ones in a word, and this block produces words of a requested Hamming weight. It drives on-chip stimulus for calc_hamming and any weight-sensitive logic. Bit positions come from a seeded LFSR, so a given seed always reproduces the same word sequence.

Parameters:
DEFAULT_SEED, 32'hACE1_0001, LFSR value after reset and substitute for an all-zero SEED load.
TAPS, 32'h8020_0003, Galois LFSR feedback mask.

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request generation; sampled only in IDLE
WEIGHT  input  6  requested number of ones, legal range 0..32; latched with START
LOAD_SEED  input  1  load SEED into LFSR; honoured only in IDLE
SEED  input  32  LFSR seed value
DATA  output  32  generated word; registered and held until the next accepted START
BUSY  output  1  high while in FILL
DONE  output  1  one-cycle pulse; DATA is final while DONE is high
ERR  output  1  one-cycle pulse on START with WEIGHT > 32

Behaviour:
- Reset, any cycle including mid-FILL: state=IDLE, DATA=0, LFSR=DEFAULT_SEED, remaining=0, BUSY=DONE=ERR=0.
- FSM states: IDLE, FILL, FIN. BUSY=(state==FILL). DONE=(state==FIN). Both are decoded from the state register.
- IDLE, LOAD_SEED=1: LFSR<=SEED, or DEFAULT_SEED if SEED==0. If START is also high in the same cycle, it is processed in that cycle and the first fill uses the new seed.
- IDLE, START=1 and WEIGHT<=16: mode=SET, DATA<=0, remaining<=WEIGHT.
- IDLE, START=1 and 17<=WEIGHT<=32: mode=CLEAR, DATA<=32'hFFFF_FFFF, remaining<=32-WEIGHT.
- After either START case: next state is FIN if remaining==0, otherwise FILL.
- IDLE, START=1 and WEIGHT>32: ERR=1 for the next cycle only. DATA, LFSR and state are unchanged.
- FILL, each cycle:
  - p=LFSR[4:0].
  - Target index i = first index scanning p, p+1, ... (mod 32) with DATA[i]==0 in SET mode, or DATA[i]==1 in CLEAR mode. This is a rotate-and-priority search. A target always exists while remaining>0.
  - Toggle DATA[i], then remaining<=remaining-1.
  - LFSR advance: LFSR<=(LFSR>>1) ^ (LFSR[0] ? TAPS : 0).
  - Next state is FIN when remaining==1, otherwise stay in FILL.
- LFSR advances only in FILL and holds in every other state.
- FIN: lasts one cycle, then IDLE.
- Latency with r=min(WEIGHT, 32-WEIGHT):
  - START sampled at edge n.
  - BUSY is high for exactly r cycles (edges n..n+r).
  - DONE is high between edges n+r and n+r+1.
  - Maximum r is 16, so worst-case START-to-DONE is 17 cycles.
- START, LOAD_SEED and WEIGHT are ignored in FILL and FIN; no queuing.
- Invariant when DONE is high: popcount(DATA)==WEIGHT as latched.

Test Plan:
- Reset check: assert RST 2 cycles -> DATA=0, BUSY=0, DONE=0, ERR=0; release, no START -> outputs stay 0, LFSR unchanged.
- Zero-fill cases: WEIGHT=0 -> DONE the cycle after START, BUSY never high, DATA=0. WEIGHT=32 -> DONE the cycle after START, DATA=FFFF_FFFF.
- Mid-weight cases with DATA fed into a calc_hamming instance:
  - WEIGHT=16, default seed -> BUSY exactly 16 cycles, RESULT=16 at DONE.
  - WEIGHT=31 -> BUSY 1 cycle, RESULT=31.
  - WEIGHT=1 -> single set bit at index DEFAULT_SEED[4:0]=1, DATA=32'h0000_0002.
- Illegal weight: WEIGHT=40 -> ERR pulse 1 cycle, BUSY/DONE stay 0, DATA holds its previous word.
- Reproducibility sweep: LOAD_SEED with SEED=32'h1234_5678, sweep WEIGHT 0..32 -> every DONE gives RESULT==WEIGHT and DATA matches the bench reference model. Reload the same seed and repeat -> identical DATA sequence. SEED=0 -> same sequence as DEFAULT_SEED.
- Protocol abuse:
  - START and LOAD_SEED pulsed during FILL -> ignored; DONE timing and DATA unaffected.
  - RST asserted at the 5th FILL cycle of WEIGHT=12 -> next cycle all outputs at reset values; a following START with WEIGHT=12 completes normally.

Source files
------------

// File: rtl/weight_pattern_gen.sv
// rtl/weight_pattern_gen.sv - generator of 32-bit words with a requested number of ones
//
// Purpose: on START, builds a word with exactly WEIGHT ones. Words with
// WEIGHT <= 16 start from all-zeros and set bits; heavier words start from
// all-ones and clear bits, so at most 16 FILL cycles are needed. Each FILL
// cycle picks the first eligible bit at or after an LFSR-chosen position.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      generation request, sampled in IDLE only
//   weight_i     requested weight 0..32, latched with start_i
//   load_seed_i  load seed_i into the LFSR, honoured in IDLE only
//   seed_i       LFSR seed (zero maps to DEFAULT_SEED)
//   data_o       generated word, held until the next accepted start
//   busy_o       high while filling
//   done_o       one-cycle pulse, data_o final
//   err_o        one-cycle pulse after a start with weight_i > 32
module weight_pattern_gen #(
  parameter logic [31:0] DEFAULT_SEED = 32'hACE1_0001,
  parameter logic [31:0] TAPS         = 32'h8020_0003
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  weight_i,
  input  logic        load_seed_i,
  input  logic [31:0] seed_i,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, FILL, FIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [5:0]  rem_q, rem_d;
  logic        clear_q, clear_d;
  logic        err_q, err_d;

  // Rotate-and-priority search for the target bit.
  logic [4:0]  pos;
  logic [31:0] cand;
  logic [63:0] dbl;
  logic [31:0] rot;
  logic [4:0]  first;
  logic [4:0]  tgt;

  always_comb begin
    pos  = lfsr_q[4:0];
    // Eligible bits: zeros when setting, ones when clearing.
    cand = clear_q ? data_q : ~data_q;
    dbl  = {cand, cand} >> pos;
    rot  = dbl[31:0];
    first = 5'd0;
    // Descending scan so the lowest set bit of rot wins.
    for (int j = 31; j >= 0; j--) begin
      if (rot[j]) first = 5'(j);
    end
    // 5-bit add wraps modulo 32, undoing the rotation.
    tgt = pos + first;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lfsr_d  = lfsr_q;
    rem_d   = rem_q;
    clear_d = clear_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_seed_i) begin
          lfsr_d = (seed_i == 32'd0) ? DEFAULT_SEED : seed_i;
        end
        if (start_i) begin
          if (weight_i > 6'd32) begin
            err_d = 1'b1;
          end else if (weight_i <= 6'd16) begin
            clear_d = 1'b0;
            data_d  = 32'd0;
            rem_d   = weight_i;
            state_d = (weight_i == 6'd0) ? FIN : FILL;
          end else begin
            clear_d = 1'b1;
            data_d  = 32'hFFFF_FFFF;
            rem_d   = 6'd32 - weight_i;
            state_d = (weight_i == 6'd32) ? FIN : FILL;
          end
        end
      end
      FILL: begin
        data_d  = data_q ^ (32'd1 << tgt);
        rem_d   = rem_q - 6'd1;
        lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'd0);
        if (rem_q == 6'd1) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= 32'd0;
      lfsr_q  <= DEFAULT_SEED;
      rem_q   <= 6'd0;
      clear_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lfsr_q  <= lfsr_d;
      rem_q   <= rem_d;
      clear_q <= clear_d;
      err_q   <= err_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = (state_q == FILL);
  assign done_o = (state_q == FIN);
  assign err_o  = err_q;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// tb/tb_weight_pattern_gen.sv - self-checking bench for weight_pattern_gen
module tb_weight_pattern_gen;

  localparam logic [31:0] DEF  = 32'hACE1_0001;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  weight_i = 6'd0;
  logic        load_seed_i = 1'b0;
  logic [31:0] seed_i = 32'd0;
  logic [31:0] data_o;
  logic        busy_o, done_o, err_o;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_lfsr;
  logic [31:0] seq_a [0:32];

  weight_pattern_gen #(.DEFAULT_SEED(DEF), .TAPS(TAPS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .weight_i(weight_i),
    .load_seed_i(load_seed_i), .seed_i(seed_i), .data_o(data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: plain bit-by-bit walk from the LFSR position.
  task automatic m_gen(input logic [5:0] w, input logic ld, input logic [31:0] sd,
                       output logic [31:0] d);
    logic clr;
    int   r;
    int   idx;
    bit   hit;
    if (ld) m_lfsr = (sd == 32'd0) ? DEF : sd;
    clr = (w > 6'd16);
    d   = clr ? 32'hFFFF_FFFF : 32'd0;
    r   = clr ? 32 - int'(w) : int'(w);
    for (int s = 0; s < r; s++) begin
      hit = 1'b0;
      for (int k = 0; k < 32; k++) begin
        idx = (int'(m_lfsr[4:0]) + k) % 32;
        if (!hit && d[idx] == clr) begin
          d[idx] = ~clr;
          hit = 1'b1;
        end
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
    end
  endtask

  // Drives one request and reports what the DUT did; abuse pulses
  // start/load_seed throughout FILL.
  task automatic run_gen(input logic [5:0] w, input logic ld, input logic [31:0] sd,
                         input logic abuse, output logic [31:0] d, output int bc,
                         output logic dn, output logic er);
    start_i = 1'b1; weight_i = w; load_seed_i = ld; seed_i = sd;
    tick();
    start_i = 1'b0; load_seed_i = 1'b0;
    er = err_o;
    bc = 0;
    while (busy_o && bc < 40) begin
      bc++;
      if (abuse) begin
        start_i = 1'b1; load_seed_i = 1'b1; seed_i = 32'hDEAD_BEEF; weight_i = 6'd3;
      end
      tick();
      start_i = 1'b0; load_seed_i = 1'b0;
    end
    dn = done_o;
    d  = data_o;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    n_total++;
    if ({data_o, busy_o, done_o, err_o} !== 35'd0)
      $display("FAIL reset_state: got data=%h busy=%b done=%b err=%b, want all 0",
               data_o, busy_o, done_o, err_o);
    else n_pass++;
    rst_i = 1'b0;
    tick(); tick(); tick();
    n_total++;
    if ({data_o, busy_o, done_o, err_o} !== 35'd0)
      $display("FAIL reset_idle: got data=%h busy=%b done=%b err=%b, want all 0",
               data_o, busy_o, done_o, err_o);
    else n_pass++;
    m_lfsr = DEF;
  endtask

  task automatic test_small_weights();
    logic [31:0] d, md;
    int bc;
    logic dn, er;
    // Straight after reset: position DEF[4:0] = 1 -> bit 1.
    run_gen(6'd1, 1'b0, 32'd0, 1'b0, d, bc, dn, er);
    m_gen(6'd1, 1'b0, 32'd0, md);
    n_total++;
    if (d !== 32'h0000_0002 || bc != 1 || dn !== 1'b1)
      $display("FAIL weight1: got data=%h busy=%0d done=%b, want 00000002/1/1", d, bc, dn);
    else n_pass++;
    // Seed 0 reload maps to default; second position 3 -> bits 1,3.
    run_gen(6'd2, 1'b1, 32'd0, 1'b0, d, bc, dn, er);
    m_gen(6'd2, 1'b1, 32'd0, md);
    n_total++;
    if (d !== 32'h0000_000A || bc != 2 || dn !== 1'b1)
      $display("FAIL weight2: got data=%h busy=%0d done=%b, want 0000000a/2/1", d, bc, dn);
    else n_pass++;
  endtask

  task automatic test_zero_fill();
    logic [31:0] d, md;
    int bc;
    logic dn, er;
    run_gen(6'd0, 1'b0, 32'd0, 1'b0, d, bc, dn, er);
    m_gen(6'd0, 1'b0, 32'd0, md);
    n_total++;
    if (d !== 32'd0 || bc != 0 || dn !== 1'b1)
      $display("FAIL weight0: got data=%h busy=%0d done=%b, want 00000000/0/1", d, bc, dn);
    else n_pass++;
    run_gen(6'd32, 1'b0, 32'd0, 1'b0, d, bc, dn, er);
    m_gen(6'd32, 1'b0, 32'd0, md);
    n_total++;
    if (d !== 32'hFFFF_FFFF || bc != 0 || dn !== 1'b1)
      $display("FAIL weight32: got data=%h busy=%0d done=%b, want ffffffff/0/1", d, bc, dn);
    else n_pass++;
  endtask

  task automatic test_mid_weights();
    logic [31:0] d, md;
    int bc;
    logic dn, er;
    run_gen(6'd16, 1'b1, 32'd0, 1'b0, d, bc, dn, er);
    m_gen(6'd16, 1'b1, 32'd0, md);
    n_total++;
    if ($countones(d) != 16 || bc != 16 || dn !== 1'b1 || d !== md)
      $display("FAIL weight16: got data=%h ones=%0d busy=%0d done=%b, want %h/16/16/1",
               d, $countones(d), bc, dn, md);
    else n_pass++;
    // Clear mode, position 1 from default seed -> bit 1 cleared.
    run_gen(6'd31, 1'b1, 32'd0, 1'b0, d, bc, dn, er);
    m_gen(6'd31, 1'b1, 32'd0, md);
    n_total++;
    if (d !== 32'hFFFF_FFFD || bc != 1 || dn !== 1'b1)
      $display("FAIL weight31: got data=%h busy=%0d done=%b, want fffffffd/1/1", d, bc, dn);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] d, md;
    int bc;
    logic dn, er;
    run_gen(6'd40, 1'b0, 32'd0, 1'b0, d, bc, dn, er);
    n_total++;
    if (er !== 1'b1 || bc != 0 || dn !== 1'b0 || d !== 32'hFFFF_FFFD)
      $display("FAIL illegal_weight: got err=%b busy=%0d done=%b data=%h, want 1/0/0/fffffffd",
               er, bc, dn, d);
    else n_pass++;
    n_total++;
    if (err_o !== 1'b0)
      $display("FAIL err_pulse_width: got err=%b one cycle later, want 0", err_o);
    else n_pass++;
    // LFSR must not have moved: the next word still follows the model.
    run_gen(6'd5, 1'b0, 32'd0, 1'b0, d, bc, dn, er);
    m_gen(6'd5, 1'b0, 32'd0, md);
    n_total++;
    if (d !== md || bc != 5 || er !== 1'b0)
      $display("FAIL after_illegal: got data=%h busy=%0d err=%b, want %h/5/0", d, bc, er, md);
    else n_pass++;
  endtask

  task automatic sweep(input logic [31:0] sd, input logic cmp, input string tag);
    logic [31:0] d, md;
    int bc, r;
    logic dn, er;
    for (int w = 0; w <= 32; w++) begin
      r = (w > 16) ? 32 - w : w;
      run_gen(6'(w), w == 0, sd, 1'b0, d, bc, dn, er);
      m_gen(6'(w), w == 0, sd, md);
      n_total++;
      if ($countones(d) != w || d !== md || bc != r || dn !== 1'b1)
        $display("FAIL %s w=%0d: got data=%h busy=%0d done=%b, want %h/%0d/1",
                 tag, w, d, bc, dn, md, r);
      else n_pass++;
      if (cmp) begin
        n_total++;
        if (d !== seq_a[w])
          $display("FAIL %s_repeat w=%0d: got data=%h, want %h", tag, w, d, seq_a[w]);
        else n_pass++;
      end
      seq_a[w] = d;
    end
  endtask

  task automatic test_sweep();
    sweep(32'h1234_5678, 1'b0, "sweep_seed");
    sweep(32'h1234_5678, 1'b1, "reload_seed");
    sweep(DEF, 1'b0, "sweep_default");
    sweep(32'd0, 1'b1, "seed_zero");
  endtask

  task automatic test_back_to_back_abuse();
    logic [31:0] d, md;
    int bc;
    logic dn, er;
    run_gen(6'd16, 1'b1, 32'h0BAD_F00D, 1'b1, d, bc, dn, er);
    m_gen(6'd16, 1'b1, 32'h0BAD_F00D, md);
    n_total++;
    if (d !== md || bc != 16 || dn !== 1'b1)
      $display("FAIL abuse_fill: got data=%h busy=%0d done=%b, want %h/16/1", d, bc, dn, md);
    else n_pass++;
    run_gen(6'd20, 1'b0, 32'd0, 1'b0, d, bc, dn, er);
    m_gen(6'd20, 1'b0, 32'd0, md);
    n_total++;
    if (d !== md || bc != 12 || dn !== 1'b1)
      $display("FAIL abuse_next: got data=%h busy=%0d done=%b, want %h/12/1", d, bc, dn, md);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d, md;
    int bc;
    logic dn, er;
    start_i = 1'b1; weight_i = 6'd12;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick(); tick();
    n_total++;
    if (busy_o !== 1'b1)
      $display("FAIL mid_fill_busy: got busy=%b, want 1", busy_o);
    else n_pass++;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_total++;
    if ({data_o, busy_o, done_o, err_o} !== 35'd0)
      $display("FAIL mid_fill_reset: got data=%h busy=%b done=%b err=%b, want all 0",
               data_o, busy_o, done_o, err_o);
    else n_pass++;
    m_lfsr = DEF;
    run_gen(6'd12, 1'b0, 32'd0, 1'b0, d, bc, dn, er);
    m_gen(6'd12, 1'b0, 32'd0, md);
    n_total++;
    if (d !== md || bc != 12 || dn !== 1'b1 || $countones(d) != 12)
      $display("FAIL after_reset_w12: got data=%h busy=%0d done=%b, want %h/12/1", d, bc, dn, md);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_small_weights();
    test_zero_fill();
    test_mid_weights();
    test_illegal();
    test_sweep();
    test_back_to_back_abuse();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
